// File: rtl/serial_tx_frame.sv
// serial_tx_frame
//   Serial frame transmitter. A parallel word is accepted through a
//   valid/ready handshake. It is then sent on the serial line as a frame:
//   one start bit (0), DATA_W data bits LSB first, an optional odd-parity
//   bit, and one stop bit (1). Every line bit is held for CLKS_PER_BIT
//   clock cycles.
//
// Ports
//   i_clk       clock, all state updates on the rising edge
//   i_reset     asynchronous active-high reset
//   i_in_valid  producer has a word on i_in_data
//   i_in_data   word to send, sampled only on an accept edge
//   o_in_ready  block can accept a word this cycle
//   o_out       serial line, idles high
//   o_busy      a frame is in progress
//   o_done      high throughout the stop-bit period of each frame
module serial_tx_frame #(
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 1,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_out,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t            r_state, w_state_next;
  logic [DATA_W-1:0] r_shift, w_shift_next;
  logic              r_parity, w_parity_next;
  logic [IW-1:0]     r_bit_idx, w_bit_idx_next;
  logic [CW-1:0]     r_timer, w_timer_next;

  logic w_tick;
  logic w_accept;

  // The last cycle of the current bit period.
  assign w_tick = (r_timer == LAST_TICK);

  // Ready in IDLE, and in the final stop cycle so that frames can follow
  // each other with no idle gap.
  assign o_in_ready = (r_state == S_IDLE) || ((r_state == S_STOP) && w_tick);
  assign w_accept   = i_in_valid && o_in_ready;

  // The outputs are decoded from registers only, so the inputs have no
  // path to the line.
  always_comb begin
    o_out = 1'b1;
    case (r_state)
      S_START: o_out = 1'b0;
      S_DATA:  o_out = r_shift[0];
      S_PAR:   o_out = r_parity;
      default: o_out = 1'b1;
    endcase
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_done = (r_state == S_STOP);

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_parity_next  = r_parity;
    w_bit_idx_next = r_bit_idx;
    w_timer_next   = r_timer;

    if (w_accept) begin
      w_state_next   = S_START;
      w_shift_next   = i_in_data;
      w_parity_next  = ~^i_in_data;
      w_bit_idx_next = '0;
      w_timer_next   = '0;
    end else if (r_state != S_IDLE) begin
      w_timer_next = w_tick ? '0 : r_timer + 1'b1;
      if (w_tick) begin
        case (r_state)
          S_START: begin
            w_state_next   = S_DATA;
            w_bit_idx_next = '0;
          end
          S_DATA: begin
            w_shift_next = r_shift >> 1;
            if (r_bit_idx == LAST_IDX) begin
              w_state_next = (PARITY_EN != 0) ? S_PAR : S_STOP;
            end else begin
              w_bit_idx_next = r_bit_idx + 1'b1;
            end
          end
          S_PAR:   w_state_next = S_STOP;
          S_STOP:  w_state_next = S_IDLE;
          default: w_state_next = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_bit_idx <= '0;
      r_timer   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_parity  <= w_parity_next;
      r_bit_idx <= w_bit_idx_next;
      r_timer   <= w_timer_next;
    end
  end

endmodule

// File: tb/tb_serial_tx_frame.sv
// Testbench for serial_tx_frame. DUT "a" uses the default parameters
// (8 data bits, odd parity, 1 clock per bit). DUT "b" has no parity bit
// and 3 clocks per bit. Expected line waveforms come from a frame model
// built from the frame-format rules.
module tb_serial_tx_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_valid, a_ready, a_out, a_busy, a_done;
  logic [7:0] a_data;
  logic       b_valid, b_ready, b_out, b_busy, b_done;
  logic [7:0] b_data;

  serial_tx_frame #(.DATA_W(8), .PARITY_EN(1), .CLKS_PER_BIT(1)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_in_valid(a_valid), .i_in_data(a_data),
    .o_in_ready(a_ready), .o_out(a_out), .o_busy(a_busy), .o_done(a_done)
  );

  serial_tx_frame #(.DATA_W(8), .PARITY_EN(0), .CLKS_PER_BIT(3)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_in_valid(b_valid), .i_in_data(b_data),
    .o_in_ready(b_ready), .o_out(b_out), .o_busy(b_busy), .o_done(b_done)
  );

  int checks   = 0;
  int failures = 0;

  bit   exp_q[$];
  logic obs_out[64];
  logic obs_busy[64];
  logic obs_done[64];
  logic obs_ready[64];

  // Appends the expected line waveform of one frame to exp_q.
  function automatic void build_frame(input logic [7:0] d, input bit par_en, input int cpb);
    bit bits[$];
    int ones;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (par_en) bits.push_back((ones % 2) == 0);
    bits.push_back(1'b1);
    foreach (bits[j]) for (int r = 0; r < cpb; r++) exp_q.push_back(bits[j]);
  endfunction

  task automatic cap_a(input int i);
    obs_out[i] = a_out; obs_busy[i] = a_busy; obs_done[i] = a_done; obs_ready[i] = a_ready;
  endtask

  task automatic cap_b(input int i);
    obs_out[i] = b_out; obs_busy[i] = b_busy; obs_done[i] = b_done; obs_ready[i] = b_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_valid = 1'b0; a_data = 8'h00; b_valid = 1'b0; b_data = 8'h00;
    #12;
    checks++;
    if (a_out !== 1'b1 || a_busy !== 1'b0 || a_done !== 1'b0 || a_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_a out/busy/done/ready got=%b%b%b%b exp=1001", a_out, a_busy, a_done, a_ready);
    end
    checks++;
    if (b_out !== 1'b1 || b_busy !== 1'b0 || b_done !== 1'b0 || b_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_b out/busy/done/ready got=%b%b%b%b exp=1001", b_out, b_busy, b_done, b_ready);
    end
    // Release reset with a word already offered: it must be taken at the
    // very first rising edge.
    @(negedge clk);
    rst = 1'b0; a_valid = 1'b1; a_data = 8'h3C;
    @(negedge clk);
    a_valid = 1'b0;
    checks++;
    if (a_out !== 1'b0 || a_busy !== 1'b1) begin
      failures++;
      $display("FAIL first_accept out/busy got=%b%b exp=01", a_out, a_busy);
    end
    repeat (11) @(negedge clk);
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_frame(input logic [7:0] d);
    exp_q.delete();
    build_frame(d, 1'b1, 1);
    @(negedge clk);
    a_valid = 1'b1; a_data = d;
    checks++;
    if (a_ready !== 1'b1) begin
      failures++;
      $display("FAIL frame_%h ready_idle got=%b exp=1", d, a_ready);
    end
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      cap_a(i);
      if (i == 0) begin a_valid = 1'b0; a_data = 8'($urandom); end
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (obs_out[i] !== exp_q[i] || obs_busy[i] !== 1'b1 ||
          obs_done[i] !== (i == 10) || obs_ready[i] !== (i == 10)) begin
        failures++;
        $display("FAIL frame_%h cyc%0d out/busy/done/ready got=%b%b%b%b exp=%b1%b%b",
                 d, i, obs_out[i], obs_busy[i], obs_done[i], obs_ready[i], exp_q[i], i == 10, i == 10);
      end
    end
    @(negedge clk);
    checks++;
    if (a_out !== 1'b1 || a_busy !== 1'b0 || a_done !== 1'b0 || a_ready !== 1'b1) begin
      failures++;
      $display("FAIL frame_%h idle got=%b%b%b%b exp=1001", d, a_out, a_busy, a_done, a_ready);
    end
    $display("test_frame data=%h checks=%0d failures=%0d", d, checks, failures);
  endtask

  task automatic test_back_to_back(input logic [7:0] d0, input logic [7:0] d1);
    exp_q.delete();
    build_frame(d0, 1'b1, 1);
    build_frame(d1, 1'b1, 1);
    @(negedge clk);
    a_valid = 1'b1; a_data = d0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      cap_a(i);
      if (i == 0) a_data = d1;
      if (i == 11) a_valid = 1'b0;
    end
    for (int i = 0; i < 22; i++) begin
      checks++;
      if (obs_out[i] !== exp_q[i] || obs_busy[i] !== 1'b1 ||
          obs_done[i] !== (i == 10 || i == 21) || obs_ready[i] !== (i == 10 || i == 21)) begin
        failures++;
        $display("FAIL b2b_%h_%h cyc%0d out/busy/done/ready got=%b%b%b%b exp=%b1%b%b",
                 d0, d1, i, obs_out[i], obs_busy[i], obs_done[i], obs_ready[i], exp_q[i],
                 (i == 10 || i == 21), (i == 10 || i == 21));
      end
    end
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0 || a_out !== 1'b1) begin
      failures++;
      $display("FAIL b2b_idle busy/out got=%b%b exp=01", a_busy, a_out);
    end
    $display("test_back_to_back data=%h,%h checks=%0d failures=%0d", d0, d1, checks, failures);
  endtask

  task automatic test_ignore_midframe(input logic [7:0] d, input logic [7:0] d2);
    exp_q.delete();
    build_frame(d, 1'b1, 1);
    @(negedge clk);
    a_valid = 1'b1; a_data = d;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      cap_a(i);
      if (i == 0) a_valid = 1'b0;
      if (i == 2) begin a_valid = 1'b1; a_data = d2; end
      if (i == 5) a_data = ~d2;
      if (i == 8) a_valid = 1'b0;
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (obs_out[i] !== exp_q[i] || obs_ready[i] !== (i == 10)) begin
        failures++;
        $display("FAIL ignore_%h cyc%0d out/ready got=%b%b exp=%b%b",
                 d, i, obs_out[i], obs_ready[i], exp_q[i], i == 10);
      end
    end
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0 || a_out !== 1'b1) begin
      failures++;
      $display("FAIL ignore_idle busy/out got=%b%b exp=01", a_busy, a_out);
    end
    $display("test_ignore_midframe data=%h checks=%0d failures=%0d", d, checks, failures);
  endtask

  task automatic test_reset_mid_frame();
    exp_q.delete();
    build_frame(8'hFF, 1'b1, 1);
    @(negedge clk);
    a_valid = 1'b1; a_data = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cap_a(i);
      if (i == 0) a_valid = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs_out[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rstmid cyc%0d out got=%b exp=%b", i, obs_out[i], exp_q[i]);
      end
    end
    // Now in data bit 3: reset must take effect before the next edge.
    rst = 1'b1;
    #1;
    checks++;
    if (a_out !== 1'b1 || a_busy !== 1'b0 || a_ready !== 1'b1 || a_done !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async out/busy/ready/done got=%b%b%b%b exp=1010", a_out, a_busy, a_ready, a_done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      checks++;
      if (a_done !== 1'b0 || a_out !== 1'b1 || a_busy !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_after cyc%0d done/out/busy got=%b%b%b exp=010", i, a_done, a_out, a_busy);
      end
    end
    $display("test_reset_mid_frame checks=%0d failures=%0d", checks, failures);
    test_frame(8'h55);
  endtask

  task automatic test_noparity(input logic [7:0] d);
    exp_q.delete();
    build_frame(d, 1'b0, 3);
    @(negedge clk);
    b_valid = 1'b1; b_data = d;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      cap_b(i);
      if (i == 0) begin b_valid = 1'b0; b_data = 8'($urandom); end
    end
    for (int i = 0; i < 30; i++) begin
      checks++;
      if (obs_out[i] !== exp_q[i] || obs_busy[i] !== 1'b1 ||
          obs_done[i] !== (i >= 27) || obs_ready[i] !== (i == 29)) begin
        failures++;
        $display("FAIL nopar_%h cyc%0d out/busy/done/ready got=%b%b%b%b exp=%b1%b%b",
                 d, i, obs_out[i], obs_busy[i], obs_done[i], obs_ready[i], exp_q[i], i >= 27, i == 29);
      end
    end
    @(negedge clk);
    checks++;
    if (b_out !== 1'b1 || b_busy !== 1'b0 || b_done !== 1'b0 || b_ready !== 1'b1) begin
      failures++;
      $display("FAIL nopar_%h idle got=%b%b%b%b exp=1001", d, b_out, b_busy, b_done, b_ready);
    end
    $display("test_noparity data=%h checks=%0d failures=%0d", d, checks, failures);
  endtask

  initial begin
    test_reset();
    test_frame(8'hD2);
    repeat (5) test_frame(8'($urandom));
    test_back_to_back(8'h01, 8'h00);
    test_back_to_back(8'($urandom), 8'($urandom));
    test_ignore_midframe(8'($urandom), 8'($urandom));
    test_reset_mid_frame();
    test_noparity(8'hA5);
    test_noparity(8'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
